// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the blocking write-back data cache.
package dcache_pkg;

  localparam int unsigned DEF_LINE_BYTES = 16;
  localparam int unsigned DEF_NUM_SETS   = 16;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  function automatic int unsigned off_bits(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned line_bytes, input int unsigned num_sets);
    return ADDR_W - off_bits(line_bytes) - idx_bits(num_sets);
  endfunction

  // Word-select width; kept at least one bit so single-word lines still elaborate.
  function automatic int unsigned sel_bits(input int unsigned line_bytes);
    return (line_bytes > 4) ? $clog2(line_bytes / 4) : 1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read, synchronous line-refill and word-merge writes.
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int unsigned LINE_BYTES = DEF_LINE_BYTES,
  parameter  int unsigned NUM_SETS   = DEF_NUM_SETS,
  localparam int unsigned IDX        = idx_bits(NUM_SETS),
  localparam int unsigned TAG        = tag_bits(LINE_BYTES, NUM_SETS),
  localparam int unsigned SEL        = sel_bits(LINE_BYTES),
  localparam int unsigned LINE_W     = 8 * LINE_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX-1:0]    rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG-1:0]    rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              line_we,
  input  logic [IDX-1:0]    line_idx,
  input  logic [TAG-1:0]    line_tag,
  input  logic [LINE_W-1:0] line_data,
  input  logic              word_we,
  input  logic [IDX-1:0]    word_idx,
  input  logic [SEL-1:0]    word_sel,
  input  logic [WORD_W-1:0] word_data
);

  localparam int unsigned WORDS = LINE_BYTES / 4;

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG-1:0]      tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // Only the state bits are reset; stale tags/data are harmless once valid is clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[line_idx] <= 1'b1;
      dirty_q[line_idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[word_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end else if (word_we) begin
      for (int w = 0; w < WORDS; w++) begin
        if (word_sel == SEL'(w)) data_q[word_idx][w*WORD_W +: WORD_W] <= word_data;
      end
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Blocking direct-mapped write-back/write-allocate data cache front end for the MEM stage.
// Optional DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter  int unsigned LINE_BYTES = DEF_LINE_BYTES,
  parameter  int unsigned NUM_SETS   = DEF_NUM_SETS,
  localparam int unsigned LINE_W     = 8 * LINE_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_input_valid,
  input  logic [31:0]       addr,
  input  logic              mem_rw,
  input  logic [31:0]       din,
  output logic              is_ready,
  output logic              is_output_valid,
  output logic [31:0]       dout,
  output logic              is_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [31:0]       mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned OFF   = off_bits(LINE_BYTES);
  localparam int unsigned IDX   = idx_bits(NUM_SETS);
  localparam int unsigned TAG   = tag_bits(LINE_BYTES, NUM_SETS);
  localparam int unsigned SEL   = sel_bits(LINE_BYTES);
  localparam int unsigned WORDS = LINE_BYTES / 4;

  state_t state_q, state_d;

  logic [31:0] req_addr_q, req_din_q;
  logic        req_rw_q;
  logic        capture;

  logic              ready_d, ovalid_d, hit_d;
  logic [31:0]       dout_d;
  logic              mreq_valid_d, mreq_write_d;
  logic [31:0]       mreq_addr_d;
  logic [LINE_W-1:0] mreq_wdata_d;

  logic [31:0]       lk_addr;
  logic [IDX-1:0]    lk_idx;
  logic [TAG-1:0]    lk_tag;
  logic [SEL-1:0]    lk_sel;
  logic              rd_valid, rd_dirty, lk_hit;
  logic [TAG-1:0]    rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [31:0]       lk_word, refill_word;
  logic              line_we, word_we;

  // In IDLE the lookup uses the incoming request so a hit response can be registered at acceptance.
  assign lk_addr     = (state_q == IDLE) ? addr : req_addr_q;
  assign lk_idx      = IDX'(lk_addr >> OFF);
  assign lk_tag      = TAG'(lk_addr >> (OFF + IDX));
  assign lk_sel      = (WORDS > 1) ? SEL'(lk_addr >> 2) : '0;
  assign lk_hit      = rd_valid && (rd_tag == lk_tag);
  assign lk_word     = WORD_W'(rd_line >> {lk_sel, 5'b0});
  assign refill_word = WORD_W'(mem_resp_rdata >> {lk_sel, 5'b0});

  dcache_array #(
    .LINE_BYTES (LINE_BYTES),
    .NUM_SETS   (NUM_SETS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (lk_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .line_we   (line_we),
    .line_idx  (lk_idx),
    .line_tag  (lk_tag),
    .line_data (mem_resp_rdata),
    .word_we   (word_we),
    .word_idx  (lk_idx),
    .word_sel  (lk_sel),
    .word_data (req_din_q)
  );

  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    ovalid_d     = 1'b0;
    hit_d        = 1'b0;
    dout_d       = '0;
    mreq_valid_d = mem_req_valid;
    mreq_write_d = mem_req_write;
    mreq_addr_d  = mem_req_addr;
    mreq_wdata_d = mem_req_wdata;
    capture      = 1'b0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (is_input_valid && is_ready) begin
          capture = 1'b1;
          ready_d = 1'b0;
          state_d = COMPARE;
          if (lk_hit) begin
            ovalid_d = 1'b1;
            hit_d    = 1'b1;
            dout_d   = mem_rw ? '0 : lk_word;
          end
        end
      end
      COMPARE: begin
        if (lk_hit) begin
          word_we = req_rw_q;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          mreq_valid_d = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d      = WRITEBACK;
            mreq_write_d = 1'b1;
            mreq_addr_d  = {rd_tag, lk_idx, {OFF{1'b0}}};
            mreq_wdata_d = rd_line;
          end else begin
            state_d      = ALLOCATE;
            mreq_write_d = 1'b0;
            mreq_addr_d  = {lk_tag, lk_idx, {OFF{1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        if (mem_req_valid) begin
          if (mem_req_ready) mreq_valid_d = 1'b0;
        end else if (mem_resp_valid) begin
          state_d      = ALLOCATE;
          mreq_valid_d = 1'b1;
          mreq_write_d = 1'b0;
          mreq_addr_d  = {lk_tag, lk_idx, {OFF{1'b0}}};
        end
      end
      ALLOCATE: begin
        if (mem_req_valid) begin
          if (mem_req_ready) mreq_valid_d = 1'b0;
        end else if (mem_resp_valid) begin
          // The refilled line is known to hit, so the late response goes out as COMPARE is entered.
          line_we  = 1'b1;
          state_d  = COMPARE;
          ovalid_d = 1'b1;
          dout_d   = req_rw_q ? '0 : refill_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      is_ready        <= 1'b0;
      is_output_valid <= 1'b0;
      is_hit          <= 1'b0;
      dout            <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_write   <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_wdata   <= '0;
      req_addr_q      <= '0;
      req_din_q       <= '0;
      req_rw_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_ready        <= ready_d;
      is_output_valid <= ovalid_d;
      is_hit          <= hit_d;
      dout            <= dout_d;
      mem_req_valid   <= mreq_valid_d;
      mem_req_write   <= mreq_write_d;
      mem_req_addr    <= mreq_addr_d;
      mem_req_wdata   <= mreq_wdata_d;
      if (capture) begin
        req_addr_q <= addr;
        req_din_q  <= din;
        req_rw_q   <= mem_rw;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (is_output_valid) begin
      if (is_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder with a latency/stall-programmable backing memory model.
module tb_dcache_responder;
  import dcache_pkg::*;

  localparam int unsigned LB  = 16;
  localparam int unsigned LW  = 8 * LB;
  localparam int          LAT = 3;
  localparam int          CLEAN = 2 + LAT;
  localparam int          DIRTY = 2 + 2 * LAT;

  logic          clk, reset;
  logic          is_input_valid, mem_rw;
  logic [31:0]   addr, din;
  logic          is_ready, is_output_valid, is_hit;
  logic [31:0]   dout;
  logic          mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0]   mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_resp_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]   hit_count, miss_count;
`endif

  dcache_responder #(.LINE_BYTES(LB), .NUM_SETS(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_rw          (mem_rw),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .is_hit          (is_hit),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_rdata  (mem_resp_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  typedef struct { logic [31:0] dout; logic hit; int cyc; } exp_t;
  typedef struct { logic wr; logic [31:0] a; logic [LW-1:0] wd; } mreq_t;

  exp_t        sb[$];
  mreq_t       mlog[$];
  logic [31:0] refw [logic [31:0]];
  logic [31:0] bmw  [logic [31:0]];
  int n_checks = 0, n_pass = 0, cyc = 0, stall = 0;
  int exp_hits = 0, exp_misses = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'h5A00_0000 ^ (a * 32'd3);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return refw.exists(a) ? refw[a] : pat(a);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return bmw.exists(a) ? bmw[a] : pat(a);
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [31:0] la);
    logic [LW-1:0] l;
    for (int w = 0; w < LB / 4; w++) l[w*32 +: 32] = mem_word(la + 32'(4 * w));
    return l;
  endfunction

  function automatic logic [LW-1:0] ref_line(input logic [31:0] la);
    logic [LW-1:0] l;
    for (int w = 0; w < LB / 4; w++) l[w*32 +: 32] = ref_word(la + 32'(4 * w));
    return l;
  endfunction

  // Backing memory: optional ready stall per request, response LAT-1 cycles after the handshake.
  initial begin : backing
    int    resp_cnt;
    mreq_t r;
    resp_cnt       = 0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (reset) begin
        resp_cnt      = 0;
        stall         = 0;
        mem_req_ready = 1'b1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = r.wr ? '0 : mem_line(r.a);
        end
      end else if (mem_req_valid) begin
        if (stall > 0) begin
          mem_req_ready = 1'b0;
          stall--;
        end else begin
          mem_req_ready = 1'b1;
          r.wr = mem_req_write;
          r.a  = mem_req_addr;
          r.wd = mem_req_wdata;
          mlog.push_back(r);
          if (r.wr) for (int w = 0; w < LB / 4; w++) bmw[r.a + 32'(4 * w)] = r.wd[w*32 +: 32];
          resp_cnt = LAT - 1;
        end
      end
    end
  end

  // Response scoreboard: every response must match the oldest expectation, including its cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && is_output_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_response: got dout=%h is_hit=%b with nothing outstanding", dout, is_hit);
        end else begin
          e = sb.pop_front();
          if (e.hit) exp_hits++; else exp_misses++;
          n_checks++;
          if (dout !== e.dout) $display("FAIL resp_dout: got %h expected %h", dout, e.dout);
          else n_pass++;
          n_checks++;
          if (is_hit !== e.hit) $display("FAIL resp_is_hit: got %b expected %b", is_hit, e.hit);
          else n_pass++;
          n_checks++;
          if (cyc !== e.cyc) $display("FAIL resp_cycle: got %0d expected %0d", cyc, e.cyc);
          else n_pass++;
        end
      end
    end
  end

  task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_hit, input int lat, output int acc);
    exp_t e;
    int   n;
    @(negedge clk);
    is_input_valid = 1'b1;
    addr           = a;
    mem_rw         = rw;
    din            = d;
    n              = 0;
    while (is_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (is_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL accept_timeout: addr %h not accepted within 200 cycles", a);
      is_input_valid = 1'b0;
      return;
    end
    e.dout = rw ? 32'h0 : ref_word(a);
    e.hit  = exp_hit;
    e.cyc  = acc + lat;
    sb.push_back(e);
    if (rw) refw[a] = d;
    @(posedge clk);
    #1 is_input_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || is_ready !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 200) $display("FAIL drain_timeout: %0d responses still outstanding", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (is_ready !== 1'b0) $display("FAIL reset_is_ready: got %b expected 0", is_ready); else n_pass++;
    n_checks++; if (is_output_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", is_output_valid); else n_pass++;
    n_checks++; if (dout !== 32'h0) $display("FAIL reset_dout: got %h expected 0", dout); else n_pass++;
    n_checks++; if (is_hit !== 1'b0) $display("FAIL reset_is_hit: got %b expected 0", is_hit); else n_pass++;
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); else n_pass++;
    n_checks++; if (mem_req_write !== 1'b0) $display("FAIL reset_req_write: got %b expected 0", mem_req_write); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (is_ready !== 1'b1) $display("FAIL post_reset_ready: got %b expected 1", is_ready); else n_pass++;
  endtask

  task automatic test_cold_read();
    int acc, m0;
    m0 = mlog.size();
    issue(1'b0, 32'h40, 32'h0, 1'b0, CLEAN, acc);
    drain();
    issue(1'b0, 32'h40, 32'h0, 1'b1, 1, acc);
    drain();
    n_checks++;
    if (mlog.size() !== m0 + 1) $display("FAIL cold_req_count: got %0d expected %0d", mlog.size(), m0 + 1);
    else begin
      n_pass++;
      n_checks++;
      if (mlog[m0].wr !== 1'b0 || mlog[m0].a !== 32'h40)
        $display("FAIL cold_req: got wr=%b addr=%h expected wr=0 addr=00000040", mlog[m0].wr, mlog[m0].a);
      else n_pass++;
    end
  endtask

  task automatic test_write_hit();
    int acc, m0;
    m0 = mlog.size();
    issue(1'b1, 32'h44, 32'hDEADBEEF, 1'b1, 1, acc);
    drain();
    issue(1'b0, 32'h44, 32'h0, 1'b1, 1, acc);
    drain();
    n_checks++;
    if (mlog.size() !== m0) $display("FAIL write_hit_no_backing: got %0d requests expected %0d", mlog.size(), m0);
    else n_pass++;
  endtask

  task automatic test_dirty_evict();
    int            acc, m0;
    logic [LW-1:0] wb_line;
    m0      = mlog.size();
    wb_line = ref_line(32'h40);
    issue(1'b0, 32'h144, 32'h0, 1'b0, DIRTY, acc);
    drain();
    n_checks++;
    if (mlog.size() !== m0 + 2) $display("FAIL evict_req_count: got %0d expected %0d", mlog.size(), m0 + 2);
    else begin
      n_pass++;
      n_checks++;
      if (mlog[m0].wr !== 1'b1 || mlog[m0].a !== 32'h40)
        $display("FAIL evict_wb_req: got wr=%b addr=%h expected wr=1 addr=00000040", mlog[m0].wr, mlog[m0].a);
      else n_pass++;
      n_checks++;
      if (mlog[m0].wd !== wb_line) $display("FAIL evict_wb_data: got %h expected %h", mlog[m0].wd, wb_line);
      else n_pass++;
      n_checks++;
      if (mlog[m0+1].wr !== 1'b0 || mlog[m0+1].a !== 32'h140)
        $display("FAIL evict_refill_req: got wr=%b addr=%h expected wr=0 addr=00000140", mlog[m0+1].wr, mlog[m0+1].a);
      else n_pass++;
    end
    // 0x44 now comes back from backing memory, carrying the written-back store.
    issue(1'b0, 32'h44, 32'h0, 1'b0, CLEAN, acc);
    drain();
  endtask

  task automatic test_stall();
    int            acc, n;
    logic [LW-1:0] wb_line;
    issue(1'b0, 32'h200, 32'h0, 1'b0, CLEAN, acc);
    drain();
    issue(1'b1, 32'h204, 32'h1234_5678, 1'b1, 1, acc);
    drain();
    wb_line = ref_line(32'h200);
    stall   = 4;
    issue(1'b0, 32'h300, 32'h0, 1'b0, DIRTY + 4, acc);
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mem_req_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b expected 1", i, mem_req_valid); else n_pass++;
      n_checks++; if (mem_req_write !== 1'b1) $display("FAIL stall_write[%0d]: got %b expected 1", i, mem_req_write); else n_pass++;
      n_checks++; if (mem_req_addr !== 32'h200) $display("FAIL stall_addr[%0d]: got %h expected 00000200", i, mem_req_addr); else n_pass++;
      n_checks++; if (mem_req_wdata !== wb_line) $display("FAIL stall_wdata[%0d]: got %h expected %h", i, mem_req_wdata, wb_line); else n_pass++;
      n_checks++; if (is_ready !== 1'b0) $display("FAIL stall_is_ready[%0d]: got %b expected 0", i, is_ready); else n_pass++;
      @(negedge clk);
    end
    drain();
  endtask

  task automatic test_reset_mid_alloc();
    int acc, n;
    stall = 2;
    issue(1'b0, 32'h500, 32'h0, 1'b0, CLEAN + 2, acc);
    n = 0;
    while (!(mem_req_valid === 1'b1 && mem_req_write === 1'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL midreset_req_valid: got %b expected 0", mem_req_valid); else n_pass++;
    n_checks++; if (is_ready !== 1'b0) $display("FAIL midreset_is_ready: got %b expected 0", is_ready); else n_pass++;
    n_checks++; if (is_output_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b expected 0", is_output_valid); else n_pass++;
    n_checks++; if (dut.state_q !== IDLE) $display("FAIL midreset_state: got %0d expected %0d", dut.state_q, IDLE); else n_pass++;
    reset      = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    issue(1'b0, 32'h500, 32'h0, 1'b0, CLEAN, acc);
    drain();
    issue(1'b0, 32'h44, 32'h0, 1'b0, CLEAN, acc);
    drain();
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3;
    issue(1'b0, 32'h500, 32'h0, 1'b1, 1, a1);
    issue(1'b1, 32'h504, 32'hCAFE_F00D, 1'b1, 1, a2);
    issue(1'b0, 32'h504, 32'h0, 1'b1, 1, a3);
    drain();
    n_checks++; if (a2 - a1 !== 2) $display("FAIL b2b_spacing_1: got %0d expected 2", a2 - a1); else n_pass++;
    n_checks++; if (a3 - a2 !== 2) $display("FAIL b2b_spacing_2: got %0d expected 2", a3 - a2); else n_pass++;
  endtask

  task automatic test_stats();
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    n_checks++; if (hit_count !== 32'(exp_hits)) $display("FAIL stats_hits: got %0d expected %0d", hit_count, exp_hits); else n_pass++;
    n_checks++; if (miss_count !== 32'(exp_misses)) $display("FAIL stats_misses: got %0d expected %0d", miss_count, exp_misses); else n_pass++;
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    reset          = 1'b1;
    is_input_valid = 1'b0;
    addr           = '0;
    mem_rw         = 1'b0;
    din            = '0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_evict();
    test_stall();
    test_reset_mid_alloc();
    test_back_to_back();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
